regfile_op_sequencer: RTL and testbench

- Multi-cycle micro-op controller for the CPU register file (W,Z,B,C,D,E,H,L / WZ,BC,DE,HL,SP,PC).
- Accepts one register-transfer request at a time over a valid/ready handshake.
- Sequences one-hot read/write strobes and write data into the register file: moves, 16-bit inc/dec, 8-bit exchange, and immediate loads.
- Sits between the instruction decoder and the register file, and shares the register file's enable.

---
 rtl/regfile_op_sequencer_pkg.sv | 60 ++++++
 rtl/regfile_op_sequencer_onehot_dec.sv | 32 +++
 rtl/regfile_op_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_regfile_op_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_op_sequencer_pkg.sv
// Shared types for the register-file micro-op sequencer: op codes,
// register codes, FSM states and request legality helpers.
package regfile_op_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MOV8  = 3'd1,
    OP_MOV16 = 3'd2,
    OP_INC16 = 3'd3,
    OP_DEC16 = 3'd4,
    OP_XCHG8 = 3'd5,
    OP_LDI8  = 3'd6,
    OP_LDI16 = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    R8_W = 3'd0, R8_Z = 3'd1, R8_B = 3'd2, R8_C = 3'd3,
    R8_D = 3'd4, R8_E = 3'd5, R8_H = 3'd6, R8_L = 3'd7
  } reg8_e;

  typedef enum logic [2:0] {
    R16_WZ = 3'd0, R16_BC = 3'd1, R16_DE = 3'd2,
    R16_HL = 3'd3, R16_SP = 3'd4, R16_PC = 3'd5
  } reg16_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_B = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_e;

  // 16-bit codes above PC do not name a register.
  function automatic logic is_legal16(input logic [2:0] code);
    return (code <= R16_PC);
  endfunction

  // Ops whose A and B operands are both 16-bit register codes.
  function automatic logic op_is16(input logic [2:0] op);
    return (op == OP_MOV16) || (op == OP_INC16) || (op == OP_DEC16);
  endfunction

  // A request is legal unless it names an illegal 16-bit code it actually uses.
  function automatic logic req_legal(input logic [2:0] op, input logic [2:0] a,
                                     input logic [2:0] b);
    logic ok;
    if (op_is16(op)) begin
      ok = is_legal16(a) && is_legal16(b);
    end else if (op == OP_LDI16) begin
      ok = is_legal16(a);
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/regfile_op_sequencer_onehot_dec.sv
// Register-code to one-hot strobe decoder with a legality flag for codes
// that fall outside the N implemented registers.
module regfile_onehot_dec #(
  parameter int N = 8
) (
  input  logic [2:0]   code,
  input  logic         en,
  output logic [N-1:0] onehot,
  output logic         legal
);

  logic [N-1:0] hit_s;

  // Match the code against each implemented register; strobe only when enabled.
  always_comb begin
    hit_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (code == 3'(i)) begin
        hit_s[i] = 1'b1;
      end else begin
        hit_s[i] = 1'b0;
      end
    end
    legal = |hit_s;
    if (en) begin
      onehot = hit_s;
    end else begin
      onehot = {N{1'b0}};
    end
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Multi-cycle register-file micro-op sequencer. Accepts one request at a
// time and walks it through read/write phases; every strobe and bus is
// decoded from the state and latched operands only.
module regfile_op_sequencer
  import regfile_op_sequencer_pkg::*;
#(
  parameter int N_REG8  = 8,
  parameter int N_REG16 = 6
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Enable,
  input  logic               i_Req_Valid,
  output logic               o_Req_Ready,
  input  logic [2:0]         i_Op,
  input  logic [2:0]         i_RegA,
  input  logic [2:0]         i_RegB,
  input  logic [15:0]        i_Imm,
  output logic [N_REG8-1:0]  o_Read8,
  output logic [N_REG8-1:0]  o_Write8,
  output logic [7:0]         o_Bus8,
  input  logic [7:0]         i_Bus8,
  output logic [N_REG16-1:0] o_Read16,
  output logic [N_REG16-1:0] o_Write16,
  output logic [15:0]        o_Bus16,
  input  logic [15:0]        i_Bus16,
  output logic               o_Busy,
  output logic               o_Done,
  output logic               o_Err
);

  state_e      state_r, state_nxt_s;
  op_e         op_r;
  logic [2:0]  reg_a_r, reg_b_r;
  logic [15:0] imm_r, tmp0_r;
  logic [7:0]  tmp1_r;
  logic        accept_s;

  logic        rd8_en_s, rd16_en_s, wr8_en_s, wr16_en_s;
  logic [2:0]  rd8_code_s, wr8_code_s, wr16_code_s;
  logic        rd8_legal_s, rd16_legal_s, wr8_legal_s, wr16_legal_s;
  logic [7:0]  wr8_data_s;
  logic [15:0] wr16_data_s, rd_data_s;
  logic        rd_ok_s;

  assign accept_s = (state_r == ST_IDLE) && i_Enable && i_Req_Valid;

  // State register; frozen whenever the system tick is low.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r <= ST_IDLE;
    end else if (i_Enable) begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: pick the path for the op at accept, then step through it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!i_Req_Valid) begin
          state_nxt_s = ST_IDLE;
        end else if (!req_legal(i_Op, i_RegA, i_RegB)) begin
          state_nxt_s = ST_ERR;
        end else begin
          case (i_Op)
            OP_NOP:            state_nxt_s = ST_DONE;
            OP_LDI8, OP_LDI16: state_nxt_s = ST_WR_A;
            default:           state_nxt_s = ST_RD_A;
          endcase
        end
      end
      ST_RD_A: begin
        if (op_r == OP_XCHG8) begin
          state_nxt_s = ST_RD_B;
        end else begin
          state_nxt_s = ST_WR_A;
        end
      end
      ST_RD_B: state_nxt_s = ST_WR_A;
      ST_WR_A: begin
        if (op_r == OP_XCHG8) begin
          state_nxt_s = ST_WR_B;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_WR_B: state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ST_IDLE;
      ST_ERR:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Read-phase data to keep in tmp0: raw bus, or the 16-bit value +/- 1.
  always_comb begin
    case (op_r)
      OP_MOV16: rd_data_s = i_Bus16;
      OP_INC16: rd_data_s = i_Bus16 + 16'd1;
      OP_DEC16: rd_data_s = i_Bus16 - 16'd1;
      default:  rd_data_s = {8'h00, i_Bus8};
    endcase
    if (op_is16(op_r)) begin
      rd_ok_s = rd16_legal_s;
    end else begin
      rd_ok_s = rd8_legal_s;
    end
  end

  // Operand latches and temporaries; all hold while the tick is low.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      op_r    <= OP_NOP;
      reg_a_r <= 3'd0;
      reg_b_r <= 3'd0;
      imm_r   <= 16'h0000;
      tmp0_r  <= 16'h0000;
      tmp1_r  <= 8'h00;
    end else if (i_Enable) begin
      if (accept_s) begin
        op_r    <= op_e'(i_Op);
        reg_a_r <= i_RegA;
        reg_b_r <= i_RegB;
        imm_r   <= i_Imm;
      end
      if ((state_r == ST_RD_A) && rd_ok_s) begin
        tmp0_r <= rd_data_s;
      end
      if ((state_r == ST_RD_B) && rd8_legal_s) begin
        tmp1_r <= i_Bus8;
      end
    end
  end

  // Read-strobe selection: A in RD_A (8- or 16-bit by op), B in RD_B.
  always_comb begin
    rd8_en_s   = 1'b0;
    rd16_en_s  = 1'b0;
    rd8_code_s = reg_a_r;
    if (state_r == ST_RD_A) begin
      rd8_en_s  = (op_r == OP_MOV8) || (op_r == OP_XCHG8);
      rd16_en_s = op_is16(op_r);
    end else if (state_r == ST_RD_B) begin
      rd8_en_s   = 1'b1;
      rd8_code_s = reg_b_r;
    end else begin
      rd8_en_s = 1'b0;
    end
  end

  // Write-strobe target and data for the current write phase.
  always_comb begin
    wr8_en_s    = 1'b0;
    wr16_en_s   = 1'b0;
    wr8_code_s  = reg_b_r;
    wr16_code_s = reg_b_r;
    wr8_data_s  = 8'h00;
    wr16_data_s = 16'h0000;
    case (state_r)
      ST_WR_A: begin
        case (op_r)
          OP_MOV8: begin
            wr8_en_s   = 1'b1;
            wr8_data_s = tmp0_r[7:0];
          end
          OP_XCHG8: begin
            wr8_en_s   = 1'b1;
            wr8_code_s = reg_a_r;
            wr8_data_s = tmp1_r;
          end
          OP_LDI8: begin
            wr8_en_s   = 1'b1;
            wr8_code_s = reg_a_r;
            wr8_data_s = imm_r[7:0];
          end
          OP_MOV16, OP_INC16, OP_DEC16: begin
            wr16_en_s   = 1'b1;
            wr16_data_s = tmp0_r;
          end
          OP_LDI16: begin
            wr16_en_s   = 1'b1;
            wr16_code_s = reg_a_r;
            wr16_data_s = imm_r;
          end
          default: wr8_en_s = 1'b0;
        endcase
      end
      ST_WR_B: begin
        wr8_en_s   = 1'b1;
        wr8_data_s = tmp0_r[7:0];
      end
      default: wr8_en_s = 1'b0;
    endcase
  end

  regfile_onehot_dec #(.N(N_REG8)) u_rd8_dec (
    .code(rd8_code_s), .en(rd8_en_s), .onehot(o_Read8), .legal(rd8_legal_s)
  );
  regfile_onehot_dec #(.N(N_REG16)) u_rd16_dec (
    .code(reg_a_r), .en(rd16_en_s), .onehot(o_Read16), .legal(rd16_legal_s)
  );
  regfile_onehot_dec #(.N(N_REG8)) u_wr8_dec (
    .code(wr8_code_s), .en(wr8_en_s), .onehot(o_Write8), .legal(wr8_legal_s)
  );
  regfile_onehot_dec #(.N(N_REG16)) u_wr16_dec (
    .code(wr16_code_s), .en(wr16_en_s), .onehot(o_Write16), .legal(wr16_legal_s)
  );

  // Write buses carry data only while a strobe to a known register is active.
  always_comb begin
    if (wr8_en_s && wr8_legal_s) begin
      o_Bus8 = wr8_data_s;
    end else begin
      o_Bus8 = 8'h00;
    end
    if (wr16_en_s && wr16_legal_s) begin
      o_Bus16 = wr16_data_s;
    end else begin
      o_Bus16 = 16'h0000;
    end
  end

  assign o_Req_Ready = (state_r == ST_IDLE);
  assign o_Busy      = (state_r != ST_IDLE);
  assign o_Done      = (state_r == ST_DONE);
  assign o_Err       = (state_r == ST_ERR);

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Self-checking bench: a behavioural register file answers the DUT's
// strobes, and per-cycle expected output snapshots are queued per request.
module tb_regfile_op_sequencer;
  import regfile_op_sequencer_pkg::*;

  typedef struct packed {
    logic [7:0]  rd8;
    logic [7:0]  wr8;
    logic [7:0]  bus8;
    logic [5:0]  rd16;
    logic [5:0]  wr16;
    logic [15:0] bus16;
    logic        busy;
    logic        done;
    logic        err;
    logic        ready;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  op = 3'd0, reg_a = 3'd0, reg_b = 3'd0;
  logic [15:0] imm = 16'h0000;
  logic [7:0]  read8, write8, bus8_o, bus8_i;
  logic [5:0]  read16, write16;
  logic [15:0] bus16_o, bus16_i;
  logic        busy, done, err;

  logic [7:0]  rf8  [8] = '{default: 8'h00};
  logic [15:0] rf16 [6] = '{default: 16'h0000};

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_op_sequencer #(.N_REG8(8), .N_REG16(6)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(enable),
    .i_Req_Valid(req_valid), .o_Req_Ready(req_ready),
    .i_Op(op), .i_RegA(reg_a), .i_RegB(reg_b), .i_Imm(imm),
    .o_Read8(read8), .o_Write8(write8), .o_Bus8(bus8_o), .i_Bus8(bus8_i),
    .o_Read16(read16), .o_Write16(write16), .o_Bus16(bus16_o), .i_Bus16(bus16_i),
    .o_Busy(busy), .o_Done(done), .o_Err(err)
  );

  // Register file read mux.
  always_comb begin
    bus8_i = 8'h00;
    for (int i = 0; i < 8; i++) if (read8[i]) bus8_i = bus8_i | rf8[i];
    bus16_i = 16'h0000;
    for (int j = 0; j < 6; j++) if (read16[j]) bus16_i = bus16_i | rf16[j];
  end

  // Register file write port, sharing the sequencer's enable.
  always @(posedge clk) begin
    if (enable && rst_n) begin
      for (int i = 0; i < 8; i++) if (write8[i]) rf8[i] <= bus8_o;
      for (int j = 0; j < 6; j++) if (write16[j]) rf16[j] <= bus16_o;
    end
  end

  function automatic obs_t sample_obs();
    obs_t o;
    o.rd8 = read8;   o.wr8 = write8;   o.bus8 = bus8_o;
    o.rd16 = read16; o.wr16 = write16; o.bus16 = bus16_o;
    o.busy = busy;   o.done = done;    o.err = err;   o.ready = req_ready;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  function automatic obs_t busy_obs();
    obs_t o;
    o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic logic [7:0] oh8(input logic [2:0] c);
    return 8'(8'b0000_0001 << c);
  endfunction

  function automatic logic [5:0] oh16(input logic [2:0] c);
    return 6'(6'b00_0001 << c);
  endfunction

  // Reference model: expected per-cycle outputs after the accept edge.
  task automatic push_expected(input logic [2:0] op_c, input logic [2:0] a,
                               input logic [2:0] b, input logic [15:0] imm_v);
    obs_t e;
    logic ok;
    if (op_c == OP_MOV16 || op_c == OP_INC16 || op_c == OP_DEC16) ok = (a <= 3'd5) && (b <= 3'd5);
    else if (op_c == OP_LDI16) ok = (a <= 3'd5);
    else ok = 1'b1;
    if (!ok) begin
      e = busy_obs(); e.err = 1'b1; exp_q.push_back(e);
    end else begin
      case (op_c)
        OP_MOV8: begin
          e = busy_obs(); e.rd8 = oh8(a); exp_q.push_back(e);
          e = busy_obs(); e.wr8 = oh8(b); e.bus8 = rf8[a]; exp_q.push_back(e);
        end
        OP_MOV16, OP_INC16, OP_DEC16: begin
          e = busy_obs(); e.rd16 = oh16(a); exp_q.push_back(e);
          e = busy_obs(); e.wr16 = oh16(b);
          if (op_c == OP_INC16)      e.bus16 = 16'(rf16[a] + 16'd1);
          else if (op_c == OP_DEC16) e.bus16 = 16'(rf16[a] - 16'd1);
          else                       e.bus16 = rf16[a];
          exp_q.push_back(e);
        end
        OP_XCHG8: begin
          e = busy_obs(); e.rd8 = oh8(a); exp_q.push_back(e);
          e = busy_obs(); e.rd8 = oh8(b); exp_q.push_back(e);
          e = busy_obs(); e.wr8 = oh8(a); e.bus8 = rf8[b]; exp_q.push_back(e);
          e = busy_obs(); e.wr8 = oh8(b); e.bus8 = rf8[a]; exp_q.push_back(e);
        end
        OP_LDI8: begin
          e = busy_obs(); e.wr8 = oh8(a); e.bus8 = imm_v[7:0]; exp_q.push_back(e);
        end
        OP_LDI16: begin
          e = busy_obs(); e.wr16 = oh16(a); e.bus16 = imm_v; exp_q.push_back(e);
        end
        default: e = busy_obs();
      endcase
      e = busy_obs(); e.done = 1'b1; exp_q.push_back(e);
    end
    exp_q.push_back(idle_obs());
  endtask

  // Issue one request at a negedge and compare every following cycle.
  // hold_n>0 drops enable after sample hold_at; abort_at>=0 resets after that sample.
  task automatic run_op(input string name, input logic [2:0] op_c, input logic [2:0] a,
                        input logic [2:0] b, input logic [15:0] imm_v,
                        input int hold_at, input int hold_n, input int abort_at);
    obs_t got, ex;
    int idx;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_before: got=%b exp=1", name, req_ready);
    end
    push_expected(op_c, a, b, imm_v);
    for (int k = 0; k < hold_n; k++) exp_q.insert(hold_at + 1, exp_q[hold_at]);
    op = op_c; reg_a = a; reg_b = b; imm = imm_v; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    op = 3'($urandom_range(7)); reg_a = 3'($urandom_range(7));
    reg_b = 3'($urandom_range(7)); imm = 16'($urandom);
    idx = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      got = sample_obs();
      ex = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL %s_cycle%0d: got=%h exp=%h", name, idx + 1, got, ex);
      end
      if (idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        got = sample_obs();
        checks++;
        if (got !== idle_obs()) begin
          errors++;
          $display("FAIL %s_reset_outputs: got=%h exp=%h", name, got, idle_obs());
        end
        exp_q.delete();
      end
      if (hold_n > 0 && idx >= hold_at && idx < hold_at + hold_n) enable = 1'b0;
      else enable = 1'b1;
      idx++;
    end
    enable = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got = sample_obs();
    checks++;
    if (got !== idle_obs()) begin
      errors++;
      $display("FAIL reset_state: got=%h exp=%h", got, idle_obs());
    end
    rst_n = 1'b1;
    @(negedge clk);
    got = sample_obs();
    checks++;
    if (got !== idle_obs()) begin
      errors++;
      $display("FAIL reset_release: got=%h exp=%h", got, idle_obs());
    end
  endtask

  task automatic test_mov8();
    run_op("ldi8_b", OP_LDI8, R8_B, 3'd0, 16'h125A, 0, 0, -1);
    run_op("mov8", OP_MOV8, R8_B, R8_L, 16'h0000, 0, 0, -1);
    checks++;
    if (rf8[R8_L] !== 8'h5A) begin
      errors++;
      $display("FAIL mov8_result: got=%h exp=5a", rf8[R8_L]);
    end
  endtask

  task automatic test_inc_dec();
    run_op("ldi16_hl", OP_LDI16, R16_HL, 3'd0, 16'hFFFF, 0, 0, -1);
    run_op("inc16_wrap", OP_INC16, R16_HL, R16_HL, 16'h0000, 0, 0, -1);
    checks++;
    if (rf16[R16_HL] !== 16'h0000) begin
      errors++;
      $display("FAIL inc16_result: got=%h exp=0000", rf16[R16_HL]);
    end
    run_op("dec16_wrap", OP_DEC16, R16_HL, R16_HL, 16'h0000, 0, 0, -1);
    checks++;
    if (rf16[R16_HL] !== 16'hFFFF) begin
      errors++;
      $display("FAIL dec16_result: got=%h exp=ffff", rf16[R16_HL]);
    end
  endtask

  task automatic test_ldi16_mov16();
    run_op("ldi16_sp", OP_LDI16, R16_SP, 3'd0, 16'hFFFE, 0, 0, -1);
    run_op("mov16_sp_pc", OP_MOV16, R16_SP, R16_PC, 16'h0000, 0, 0, -1);
    checks++;
    if (rf16[R16_PC] !== 16'hFFFE) begin
      errors++;
      $display("FAIL mov16_pc_result: got=%h exp=fffe", rf16[R16_PC]);
    end
  endtask

  task automatic test_xchg();
    run_op("ldi8_b2", OP_LDI8, R8_B, 3'd0, 16'h0011, 0, 0, -1);
    run_op("ldi8_c", OP_LDI8, R8_C, 3'd0, 16'h0022, 0, 0, -1);
    run_op("xchg8", OP_XCHG8, R8_B, R8_C, 16'h0000, 0, 0, -1);
    checks++;
    if ({rf8[R8_B], rf8[R8_C]} !== 16'h2211) begin
      errors++;
      $display("FAIL xchg8_result: got=%h exp=2211", {rf8[R8_B], rf8[R8_C]});
    end
    run_op("ldi8_d", OP_LDI8, R8_D, 3'd0, 16'h0077, 0, 0, -1);
    run_op("xchg8_same", OP_XCHG8, R8_D, R8_D, 16'h0000, 0, 0, -1);
    checks++;
    if (rf8[R8_D] !== 8'h77) begin
      errors++;
      $display("FAIL xchg8_same_result: got=%h exp=77", rf8[R8_D]);
    end
  endtask

  task automatic test_illegal();
    run_op("mov16_bad_a", OP_MOV16, 3'd6, R16_BC, 16'h0000, 0, 0, -1);
    run_op("inc16_bad_b", OP_INC16, R16_BC, 3'd7, 16'h0000, 0, 0, -1);
    run_op("ldi16_bad", OP_LDI16, 3'd7, 3'd0, 16'h1234, 0, 0, -1);
  endtask

  task automatic test_enable_hold();
    run_op("ldi8_e", OP_LDI8, R8_E, 3'd0, 16'h0044, 0, 0, -1);
    run_op("xchg8_hold", OP_XCHG8, R8_D, R8_E, 16'h0000, 1, 3, -1);
    checks++;
    if ({rf8[R8_D], rf8[R8_E]} !== 16'h4477) begin
      errors++;
      $display("FAIL xchg8_hold_result: got=%h exp=4477", {rf8[R8_D], rf8[R8_E]});
    end
  endtask

  task automatic test_reset_mid();
    obs_t got;
    run_op("ldi8_h", OP_LDI8, R8_H, 3'd0, 16'h00AA, 0, 0, -1);
    run_op("ldi8_l", OP_LDI8, R8_L, 3'd0, 16'h00BB, 0, 0, -1);
    run_op("xchg8_abort", OP_XCHG8, R8_H, R8_L, 16'h0000, 0, 0, 2);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      got = sample_obs();
      checks++;
      if (got !== idle_obs()) begin
        errors++;
        $display("FAIL abort_idle%0d: got=%h exp=%h", k, got, idle_obs());
      end
    end
    checks++;
    if ({rf8[R8_H], rf8[R8_L]} !== 16'hAABB) begin
      errors++;
      $display("FAIL abort_regs: got=%h exp=aabb", {rf8[R8_H], rf8[R8_L]});
    end
  endtask

  task automatic test_back_to_back();
    run_op("nop", OP_NOP, 3'd0, 3'd0, 16'h0000, 0, 0, -1);
    run_op("ldi8_w", OP_LDI8, R8_W, 3'd0, 16'hFF3C, 0, 0, -1);
    run_op("mov8_w_z", OP_MOV8, R8_W, R8_Z, 16'h0000, 0, 0, -1);
    checks++;
    if (rf8[R8_Z] !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_result: got=%h exp=3c", rf8[R8_Z]);
    end
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_mov8();
    test_inc_dec();
    test_ldi16_mov16();
    test_xchg();
    test_illegal();
    test_enable_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
